// File: rtl/seq_scan_pkg.sv
// Shared definitions for the sequence-detector scan controller.
//   state_e   : controller state encoding (IDLE..REPORT, 3-bit)
//   cnt_width : bits needed to hold a popcount of a word of the given width
package seq_scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_scan_sat_acc.sv
// Saturating accumulator for the cumulative hit counter.
// Ports:
//   clk, rst   : clock and synchronous active-low reset
//   clr_i      : clear total to 0; wins over a coincident add
//   add_en_i   : add add_val_i this cycle
//   add_val_i  : increment value
//   total_o    : registered running total, sticks at all-ones
module seq_scan_sat_acc #(
  parameter int unsigned TOT_W = 16,
  parameter int unsigned ADD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             add_en_i,
  input  logic [ADD_W-1:0] add_val_i,
  output logic [TOT_W-1:0] total_o
);

  // One spare bit above the wider operand so overflow is visible before saturating
  localparam int unsigned SUM_W = ((TOT_W > ADD_W) ? TOT_W : ADD_W) + 1;
  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'({TOT_W{1'b1}});

  logic [TOT_W-1:0] total_q, total_d;
  logic [SUM_W-1:0] sum_c;

  assign sum_c = SUM_W'(total_q) + SUM_W'(add_val_i);

  // Next-value selection: clear has priority over accumulation
  always_comb begin
    total_d = total_q;
    if (clr_i) begin
      total_d = '0;
    end else if (add_en_i) begin
      total_d = (sum_c > MAX_SUM) ? {TOT_W{1'b1}} : TOT_W'(sum_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) total_q <= '0;
    else      total_q <= total_d;
  end

  assign total_o = total_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: takes a parallel word, clears the serial Moore detector,
// shifts the word out MSB-first and collects the detector response per bit.
// Ports:
//   clk, rst              : clock and synchronous active-low reset
//   in_valid/in_ready     : input word handshake (ready only in IDLE)
//   in_data               : word to scan, bit WIDTH-1 shifted first
//   det_x                 : registered serial bit to the detector
//   det_rst               : active-low detector reset, low in CLEAR or reset
//   det_z                 : detector Moore output
//   out_valid/out_ready   : result handshake
//   out_hits, out_count   : per-bit hit map and its popcount
//   clr_stats             : clear cumulative counter
//   total_hits            : saturating cumulative hit count
//   busy                  : high whenever not IDLE
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TOT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          det_x,
  output logic                          det_rst,
  input  logic                          det_z,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_hits,
  output logic [cnt_width(WIDTH)-1:0]   out_count,
  input  logic                          clr_stats,
  output logic [TOT_W-1:0]              total_hits,
  output logic                          busy
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] hits_q, hits_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_inc, idx_dec;
  logic             det_x_q, det_x_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_hits_q, out_hits_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             hs_c;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign idx_inc = idx_q + IDX_W'(1);
  assign idx_dec = idx_q - IDX_W'(1);

  // Next-state and datapath decode
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    hits_d      = hits_q;
    idx_d       = idx_q;
    det_x_d     = det_x_q;
    out_valid_d = out_valid_q;
    out_hits_d  = out_hits_q;
    out_count_d = out_count_q;
    hs_c        = 1'b0;
    case (state_q)
      IDLE: begin
        det_x_d = 1'b0;
        if (in_valid) begin
          data_d  = in_data;
          hits_d  = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        idx_d   = IDX_W'(WIDTH - 1);
        det_x_d = data_q[WIDTH-1];
        state_d = SHIFT;
      end
      SHIFT: begin
        // det_z lags det_x by one cycle; on the first bit it still shows the cleared state
        if (idx_q != IDX_W'(WIDTH - 1)) hits_d[idx_inc] = det_z;
        if (idx_q == '0) begin
          det_x_d = 1'b0;
          state_d = DRAIN;
        end else begin
          idx_d   = idx_dec;
          det_x_d = data_q[idx_dec];
        end
      end
      DRAIN: begin
        // hits_q[0] is still clear from the accept, so OR-ing in det_z places bit 0
        out_hits_d  = hits_q | WIDTH'(det_z);
        out_count_d = popcount(out_hits_d);
        out_valid_d = 1'b1;
        state_d     = REPORT;
      end
      REPORT: begin
        if (out_ready) begin
          hs_c        = 1'b1;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      hits_q      <= '0;
      idx_q       <= '0;
      det_x_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_hits_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      hits_q      <= hits_d;
      idx_q       <= idx_d;
      det_x_q     <= det_x_d;
      out_valid_q <= out_valid_d;
      out_hits_q  <= out_hits_d;
      out_count_q <= out_count_d;
    end
  end

  seq_scan_sat_acc #(
    .TOT_W (TOT_W),
    .ADD_W (CNT_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_stats),
    .add_en_i  (hs_c),
    .add_val_i (out_count_q),
    .total_o   (total_hits)
  );

  // Detector is held in reset for the single CLEAR cycle of each word
  assign det_rst   = rst & (state_q != CLEAR);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign det_x     = det_x_q;
  assign out_valid = out_valid_q;
  assign out_hits  = out_hits_q;
  assign out_count = out_count_q;

endmodule
